// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module  : seq_shift_add_mult
// Brief   : Multi-cycle shift-and-add multiplier with start/busy/done
//           handshake, full 2*WIDTH product and narrow-result overflow flag.
// Revision: 1.0
// ============================================================================
module seq_shift_add_mult #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 re,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf
);

    localparam int              CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_acc_hi;
    logic                 r_neg;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_ovf;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_ovf;

    // Negating the most negative value yields 2^(WIDTH-1), still exact as an unsigned magnitude.
    assign w_a_neg = SIGNED && a[WIDTH-1];
    assign w_b_neg = SIGNED && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Low product bits shift into the multiplier register as its bits are consumed.
    assign w_sum = {1'b0, r_acc_hi} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc = {r_acc_hi, r_mplier};
    assign w_res = r_neg ? -w_acc : w_acc;

    generate
        if (SIGNED) begin : g_ovf_signed
            assign w_ovf = (|w_res[2*WIDTH-1:WIDTH-1]) && !(&w_res[2*WIDTH-1:WIDTH-1]);
        end else begin : g_ovf_unsigned
            assign w_ovf = |w_res[2*WIDTH-1:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!re) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc_hi  <= '0;
            r_neg     <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_product <= w_res;
                    r_ovf     <= w_ovf;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == S_RUN) || (r_state == S_FIX);
    assign done    = r_done;
    assign product = r_product;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_shift_add_mult
// Brief   : Unsigned and signed instances driven in parallel, checked every
//           cycle against an arithmetic model of the multiplier.
// Revision: 1.0
// ============================================================================
module tb_seq_shift_add_mult;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           re = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;

    logic           busy_u, done_u, ovf_u;
    logic           busy_s, done_s, ovf_s;
    logic [2*W-1:0] product_u, product_s;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    int             m_remain [2];
    logic [2*W-1:0] m_pend   [2];
    logic           m_pend_o [2];
    logic [2*W-1:0] m_prod   [2];
    logic           m_ovf    [2];
    logic           m_done   [2];

    seq_shift_add_mult #(.WIDTH(W), .SIGNED(1'b0)) u_unsigned (
        .clk(clk), .re(re), .start(start), .a(a), .b(b),
        .busy(busy_u), .done(done_u), .product(product_u), .ovf(ovf_u)
    );

    seq_shift_add_mult #(.WIDTH(W), .SIGNED(1'b1)) u_signed (
        .clk(clk), .re(re), .start(start), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .product(product_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    // Reference result from plain integer arithmetic.
    function automatic void ref_mult(input int mode, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [2*W-1:0] p, output logic o);
        longint px, py, pp;
        if (mode == 0) begin
            px = longint'({1'b0, x});
            py = longint'({1'b0, y});
            pp = px * py;
            o  = (pp >= (longint'(1) << W));
        end else begin
            px = longint'($signed(x));
            py = longint'($signed(y));
            pp = px * py;
            o  = (pp < -(longint'(1) << (W-1))) || (pp > ((longint'(1) << (W-1)) - 1));
        end
        p = pp[2*W-1:0];
    endfunction

    // Cycle model: accepted start -> result WIDTH+1 edges later; reset clears everything.
    always @(posedge clk) begin
        started = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_done[m] = 1'b0;
            if (!re) begin
                m_remain[m] = 0;
                m_prod[m]   = '0;
                m_ovf[m]    = 1'b0;
            end else if (m_remain[m] > 0) begin
                m_remain[m] = m_remain[m] - 1;
                if (m_remain[m] == 0) begin
                    m_done[m] = 1'b1;
                    m_prod[m] = m_pend[m];
                    m_ovf[m]  = m_pend_o[m];
                end
            end else if (start) begin
                ref_mult(m, a, b, m_pend[m], m_pend_o[m]);
                m_remain[m] = W + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("busy_u",    64'(busy_u),    64'(m_remain[0] > 0));
            chk("done_u",    64'(done_u),    64'(m_done[0]));
            chk("product_u", 64'(product_u), 64'(m_prod[0]));
            chk("ovf_u",     64'(ovf_u),     64'(m_ovf[0]));
            chk("busy_s",    64'(busy_s),    64'(m_remain[1] > 0));
            chk("done_s",    64'(done_s),    64'(m_done[1]));
            chk("product_s", 64'(product_s), 64'(m_prod[1]));
            chk("ovf_s",     64'(ovf_s),     64'(m_ovf[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        a = x;
        b = y;
        step();
        start = 1'b0;
    endtask

    // Returns edges elapsed until done is seen; counts one edge already taken by pulse().
    task automatic wait_done(input string name, output int n);
        n = 1;
        while (!done_u && n < 60) begin
            step();
            n++;
        end
        if (!done_u) begin
            miscompares++;
            $display("FAIL %s: done timeout, got none expected pulse", name);
        end
    endtask

    task automatic lit(input string name, input logic [2*W-1:0] pu, input logic ou,
                       input logic [2*W-1:0] ps, input logic os);
        chk({name, "_u_prod"},  64'(product_u), 64'(pu));
        chk({name, "_u_ovf"},   64'(ovf_u),     64'(ou));
        chk({name, "_s_prod"},  64'(product_s), 64'(ps));
        chk({name, "_s_ovf"},   64'(ovf_s),     64'(os));
        chk({name, "_model_u"}, 64'(m_prod[0]), 64'(pu));
        chk({name, "_model_s"}, 64'(m_prod[1]), 64'(ps));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: pick = '0;
            1: pick = '1;
            2: pick = {1'b1, {(W-1){1'b0}}};
            3: pick = {1'b0, {(W-1){1'b1}}};
            4: pick = W'(1);
            default: pick = W'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        int budget;
        for (int m = 0; m < 2; m++) begin
            m_remain[m] = 0;
            m_prod[m]   = '0;
            m_ovf[m]    = 1'b0;
            m_done[m]   = 1'b0;
            m_pend[m]   = '0;
            m_pend_o[m] = 1'b0;
        end

        step();
        step();
        chk("rst_busy", 64'({busy_u, busy_s}), 64'(0));
        chk("rst_done", 64'({done_u, done_s}), 64'(0));
        lit("rst", 32'h0, 1'b0, 32'h0, 1'b0);
        re = 1'b1;
        step();

        pulse(16'd3, 16'd5);
        wait_done("t1", n);
        chk("t1_latency", 64'(n), 64'(18));
        lit("t1", 32'h0000000F, 1'b0, 32'h0000000F, 1'b0);

        pulse(16'hFFFF, 16'hFFFF);
        wait_done("t2a", n);
        lit("t2a", 32'hFFFE0001, 1'b1, 32'h00000001, 1'b0);
        pulse(16'h0000, 16'h1234);
        wait_done("t2b", n);
        lit("t2b", 32'h0, 1'b0, 32'h0, 1'b0);

        pulse(16'hFFFD, 16'd7);
        wait_done("t3a", n);
        lit("t3a", 32'h0006FFEB, 1'b1, 32'hFFFFFFEB, 1'b0);
        pulse(16'h8000, 16'h8000);
        wait_done("t3b", n);
        lit("t3b", 32'h40000000, 1'b1, 32'h40000000, 1'b1);

        start = 1'b1;
        a = 16'd2;
        b = 16'd3;
        step();
        step();
        step();
        a = 16'd4;
        b = 16'd5;
        n = 3;
        while (!done_u && n < 60) begin
            step();
            n++;
        end
        chk("t4_first_lat", 64'(n), 64'(18));
        lit("t4a", 32'd6, 1'b0, 32'd6, 1'b0);
        step();
        wait_done("t4b", n);
        start = 1'b0;
        chk("t4_gap", 64'(n), 64'(18));
        lit("t4b", 32'd20, 1'b0, 32'd20, 1'b0);

        pulse(16'd100, 16'd200);
        step();
        step();
        step();
        re = 1'b0;
        step();
        chk("t5_busy", 64'({busy_u, busy_s}), 64'(0));
        chk("t5_done", 64'({done_u, done_s}), 64'(0));
        lit("t5_rst", 32'h0, 1'b0, 32'h0, 1'b0);
        re = 1'b1;
        step();
        pulse(16'd7, 16'd6);
        wait_done("t5", n);
        chk("t5_latency", 64'(n), 64'(18));
        lit("t5", 32'd42, 1'b0, 32'd42, 1'b0);

        for (int op = 0; op < 1000; op++) begin
            pulse(pick(), pick());
            budget = 0;
            while (m_remain[0] > 0 && budget < 40) begin
                start = ($urandom_range(0, 15) == 0);
                a = W'($urandom);
                b = W'($urandom);
                re = ($urandom_range(0, 299) != 0);
                step();
                budget++;
            end
            re = 1'b1;
            start = 1'b0;
            if (budget >= 40) begin
                miscompares++;
                $display("FAIL rand_op%0d: model busy after %0d cycles expected idle", op, budget);
            end
        end

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
